// File: rtl/systolic_skew_feeder_if.sv
// Stream bundle of the systolic skew feeder: one block-wide input handshake
// and one wavefront-wide output handshake with per-row lane enables.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int LENGTH     = 4
);
    logic                                           in_valid;
    logic                                           in_ready;
    logic [0:ROWS-1][0:LENGTH-1][DATA_WIDTH-1:0]    data_in;
    logic                                           out_valid;
    logic                                           out_ready;
    logic [0:ROWS-1][DATA_WIDTH-1:0]                data_out;
    logic [ROWS-1:0]                                row_en;

    // Feeder side: consumes blocks, produces wavefront beats.
    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output row_en
    );

    // Environment side: produces blocks, consumes wavefront beats.
    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  row_en
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers one ROWS x LENGTH operand block and streams it as diagonally skewed,
// zero-padded wavefronts. Define SYSTOLIC_SKEW_FEEDER_REVERSE_EN to mirror the skew.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int LENGTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    systolic_skew_feeder_if.slave   bus,
    output logic                    busy,
    output logic                    done
);

    localparam int T     = LENGTH + ROWS - 1;
    localparam int CNT_W = (T + 1 > 1) ? $clog2(T + 1) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [0:ROWS-1][0:LENGTH-1][DATA_WIDTH-1:0] block_t;
    typedef logic [0:ROWS-1][DATA_WIDTH-1:0]             beat_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    block_t             buf_q,   buf_d;
    logic               done_q,  done_d;

    beat_t              data_out_c;
    logic [ROWS-1:0]    row_en_c;

    // Beat index at which row r presents its element k=0.
    function automatic int lead_of(input int r);
`ifdef SYSTOLIC_SKEW_FEEDER_REVERSE_EN
        return ROWS - 1 - r;
`else
        return r;
`endif
    endfunction

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = bus.data_in;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (cnt_q == CNT_W'(T - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the operand buffer is deliberately reset so a discarded
            // block never leaks into observable state after a mid-stream reset.
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    // Wavefront decode uses only registered state, so the data lanes have no
    // combinational dependence on the handshake inputs.
    always_comb begin
        data_out_c = '0;
        row_en_c   = '0;
        if (state_q == STREAM) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < LENGTH; k++) begin
                    if (cnt_q == CNT_W'(lead_of(r) + k)) begin
                        data_out_c[r] = buf_q[r][k];
                        row_en_c[r]   = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == STREAM);
    assign bus.data_out  = data_out_c;
    assign bus.row_en    = row_en_c;
    assign busy          = (state_q == STREAM);
    assign done          = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed and randomized blocks
// compared against a wavefront model derived from the skew rule.
module tb_systolic_skew_feeder;

    localparam int DATA_WIDTH = 8;
    localparam int ROWS       = 4;
    localparam int LENGTH     = 4;
    localparam int T          = LENGTH + ROWS - 1;

    typedef logic [0:ROWS-1][0:LENGTH-1][DATA_WIDTH-1:0] block_t;
    typedef logic [0:ROWS-1][DATA_WIDTH-1:0]             beat_t;

    logic clk;
    logic reset;
    logic busy;
    logic done;

    int compared   = 0;
    int mismatched = 0;

    systolic_skew_feeder_if #(
        .DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .LENGTH(LENGTH)
    ) bus ();

    systolic_skew_feeder #(
        .DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .LENGTH(LENGTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Row r starts its data at beat r (mirrored when the reverse option is built).
    function automatic void model_beat(input block_t blk, input int b,
                                       output beat_t d, output logic [ROWS-1:0] en);
        d  = '0;
        en = '0;
        for (int r = 0; r < ROWS; r++) begin
            int start;
            int k;
`ifdef SYSTOLIC_SKEW_FEEDER_REVERSE_EN
            start = ROWS - 1 - r;
`else
            start = r;
`endif
            k = b - start;
            if (k >= 0 && k < LENGTH) begin
                d[r]  = blk[r][k];
                en[r] = 1'b1;
            end
        end
    endfunction

    function automatic block_t pattern_block(input int base);
        block_t blk;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LENGTH; k++)
                blk[r][k] = DATA_WIDTH'(base + 16 * r + k + 1);
        return blk;
    endfunction

    function automatic block_t random_block();
        block_t blk;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LENGTH; k++)
                blk[r][k] = DATA_WIDTH'($urandom);
        return blk;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
        check({tag, "_row_en"},    64'(bus.row_en),    64'd0);
        check({tag, "_data_out"},  64'(bus.data_out),  64'd0);
    endtask

    task automatic check_beat(input block_t blk, input int b, input string tag);
        beat_t           ed;
        logic [ROWS-1:0] ee;
        model_beat(blk, b, ed, ee);
        check($sformatf("%s_b%0d_valid", tag, b),    64'(bus.out_valid), 64'd1);
        check($sformatf("%s_b%0d_in_ready", tag, b), 64'(bus.in_ready),  64'd0);
        check($sformatf("%s_b%0d_busy", tag, b),     64'(busy),          64'd1);
        check($sformatf("%s_b%0d_done", tag, b),     64'(done),          64'd0);
        check($sformatf("%s_b%0d_row_en", tag, b),   64'(bus.row_en),    64'(ee));
        check($sformatf("%s_b%0d_data", tag, b),     64'(bus.data_out),  64'(ed));
    endtask

    // Called at a negedge while idle; returns at the negedge after acceptance
    // with data_in scrambled to prove it is only sampled on the accepting edge.
    task automatic accept(input block_t blk, input string tag);
        check({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.data_in  = blk;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = random_block();
    endtask

    // Streams T beats from the current negedge; returns at the negedge where
    // done must be high. Optionally stalls, randomizes ready, or raises in_valid
    // with another block mid-stream (left asserted, as a holding source would).
    task automatic stream(input block_t blk, input string tag,
                          input int stall_at, input int stall_len, input bit rand_ready,
                          input int intrude_at, input block_t intruder);
        int b      = 0;
        int cycles = 0;
        int stalls = stall_len;
        while (b < T && cycles < 40 * T) begin
            if (b == intrude_at) begin
                bus.in_valid = 1'b1;
                bus.data_in  = intruder;
            end
            if (b == stall_at && stalls > 0) begin
                bus.out_ready = 1'b0;
                stalls--;
            end else if (rand_ready) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.out_ready = 1'b1;
            end
            check_beat(blk, b, tag);
            @(posedge clk);
            @(negedge clk);
            if (bus.out_ready) b++;
            cycles++;
        end
        check({tag, "_beat_count"}, 64'(b), 64'(T));
        bus.out_ready = 1'b1;
        check({tag, "_done"},      64'(done),          64'd1);
        check({tag, "_end_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_end_ready"}, 64'(bus.in_ready),  64'd1);
        check({tag, "_end_busy"},  64'(busy),          64'd0);
    endtask

    initial begin
        block_t          blk_a;
        block_t          blk_b;
        block_t          blk_r;
        logic [ROWS-1:0] exp_en0;
        logic [7:0]      exp_lead0;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset");
        check("reset_done", 64'(done), 64'd0);

        // Basic stream with the 16r+k+1 pattern.
        blk_a = pattern_block(0);
        accept(blk_a, "basic");
`ifdef SYSTOLIC_SKEW_FEEDER_REVERSE_EN
        exp_en0   = 4'b1000;
        exp_lead0 = 8'h31;
        check("basic_b0_lead_elem", 64'(bus.data_out[3]), 64'(exp_lead0));
`else
        exp_en0   = 4'b0001;
        exp_lead0 = 8'h01;
        check("basic_b0_lead_elem", 64'(bus.data_out[0]), 64'(exp_lead0));
`endif
        check("basic_b0_en_direct", 64'(bus.row_en), 64'(exp_en0));
        stream(blk_a, "basic", -1, 0, 1'b0, -1, '0);
        @(negedge clk);
        check("basic_done_pulse_end", 64'(done), 64'd0);
        check_idle("basic_after");

        // Backpressure at beat 2 for three cycles.
        accept(blk_a, "bp");
        stream(blk_a, "bp", 2, 3, 1'b0, -1, '0);
        @(negedge clk);
        check_idle("bp_after");

        // in_valid raised with a new block during STREAM and held: ignored until
        // the block completes, then accepted in the same cycle as done.
        blk_b = pattern_block(8);
        accept(blk_a, "intr");
        stream(blk_a, "intr", -1, 0, 1'b0, 1, blk_b);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = random_block();
        stream(blk_b, "intr_next", -1, 0, 1'b0, -1, '0);
        @(negedge clk);
        check_idle("intr_after");

        // Reset at beat 3: block discarded, no done, clean restart.
        accept(blk_a, "rst");
        for (int b = 0; b < 3; b++) begin
            bus.out_ready = 1'b1;
            check_beat(blk_a, b, "rst");
            @(posedge clk);
            @(negedge clk);
        end
        check_beat(blk_a, 3, "rst");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("rst_mid");
        check("rst_mid_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d_done", i), 64'(done), 64'd0);
            check($sformatf("rst_quiet%0d_valid", i), 64'(bus.out_valid), 64'd0);
        end
        accept(blk_b, "rst_new");
        stream(blk_b, "rst_new", -1, 0, 1'b0, -1, '0);
        @(negedge clk);
        check_idle("rst_new_after");

        // Randomized blocks with random downstream ready.
        for (int n = 0; n < 12; n++) begin
            blk_r = random_block();
            accept(blk_r, $sformatf("rand%0d", n));
            stream(blk_r, $sformatf("rand%0d", n), -1, 0, 1'b1, -1, '0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
